// File: rtl/corr_pkg.sv
// Shared types for the correlator window sequencer.
// CORR_WINDOW_SEQNUM_EN adds a 16-bit window index to each result.
package corr_pkg;

    localparam int CORR_TIME_W = 8;

    function automatic int corr_exp_w(input int time_w);
        return $clog2(time_w + 1);
    endfunction

    localparam int CORR_EXP_W = corr_exp_w(CORR_TIME_W);

    typedef enum logic {
        IDLE,
        RUN
    } corrWinState_t;

    typedef struct packed {
        logic [CORR_TIME_W-1:0] countX;
        logic [CORR_TIME_W-1:0] countY;
        logic [CORR_TIME_W-1:0] countIsect;
        logic [CORR_TIME_W-1:0] countSymdiff;
`ifdef CORR_WINDOW_SEQNUM_EN
        logic [15:0]            seqNum;
`endif
    } corrResult_t;

endpackage

// File: rtl/corr_result_fifo.sv
// Two-entry valid/ready FIFO of correlator results.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module corr_result_fifo
    import corr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  corrResult_t i_data,
    input  logic        i_ready,
    output logic        o_full,
    output logic        o_empty,
    output corrResult_t o_data
);

    corrResult_t mem_q [2];
    corrResult_t mem_d [2];
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pop;
    logic        push_ok;

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        pop     = (cnt_q != 2'd0) && i_ready;
        push_ok = i_push && ((cnt_q != 2'd2) || pop);
        if (push_ok) begin
            mem_d[wr_q] = i_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_full  = (cnt_q == 2'd2);
    assign o_empty = (cnt_q == 2'd0);
    assign o_data  = mem_q[rd_q];

endmodule

// File: rtl/corr_window_seq.sv
// Window sequencer and result reader for the rectangular correlator.
// Optional CORR_WINDOW_SEQNUM_EN adds o_seqNum carried with each result.
module corr_window_seq
    import corr_pkg::*;
#(
    parameter  int TIME_W = 8,
    parameter  int DROP_W = 8,
    localparam int EXP_W  = $clog2(TIME_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cg,
    input  logic              i_enable,
    input  logic [EXP_W-1:0]  i_windowLengthExp,
    output logic [EXP_W-1:0]  o_windowLengthExp,
    output logic              o_zeroCounts,
    input  logic [TIME_W-1:0] i_countX,
    input  logic [TIME_W-1:0] i_countY,
    input  logic [TIME_W-1:0] i_countIsect,
    input  logic [TIME_W-1:0] i_countSymdiff,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [TIME_W-1:0] o_countX,
    output logic [TIME_W-1:0] o_countY,
    output logic [TIME_W-1:0] o_countIsect,
    output logic [TIME_W-1:0] o_countSymdiff,
    output logic [DROP_W-1:0] o_dropCount
`ifdef CORR_WINDOW_SEQNUM_EN
    ,
    output logic [15:0]       o_seqNum
`endif
);

    if (TIME_W != CORR_TIME_W) begin : g_width_check
        $error("TIME_W must equal corr_pkg::CORR_TIME_W");
    end

    corrWinState_t     state_q, state_d;
    logic [TIME_W-1:0] wc_q, wc_d;
    logic [TIME_W-1:0] wc_raw;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [EXP_W-1:0]  exp_in;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [15:0]       seq_q, seq_d;
    logic              capture;
    corrResult_t       cap;
    corrResult_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    // Out-of-range exponents are clamped to the widest window.
    assign exp_in = (i_windowLengthExp > EXP_W'(TIME_W))
                  ? EXP_W'(TIME_W) : i_windowLengthExp;

    assign fifo_pop = !fifo_empty && i_ready;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        wc_raw  = wc_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                wc_raw = '0;
                if (i_cg) begin
                    exp_d = exp_in;
                    if (i_enable) begin
                        state_d = RUN;
                        wc_raw  = TIME_W'(1);
                        seq_d   = '0;
                    end
                end
            end
            RUN: begin
                if (i_cg) begin
                    if (!i_enable) begin
                        state_d = IDLE;
                        wc_raw  = '0;
                    end else begin
                        if (wc_q == '0) begin
                            capture = 1'b1;
                            exp_d   = exp_in;
                            seq_d   = seq_q + 16'd1;
                        end
                        wc_raw = wc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wc_raw  = '0;
            end
        endcase
        // Mask with the exponent in force for the cycle being entered.
        wc_d = wc_raw & ~({TIME_W{1'b1}} << exp_d);
        if (capture && fifo_full && !fifo_pop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_comb begin
        cap              = '0;
        cap.countX       = i_countX;
        cap.countY       = i_countY;
        cap.countIsect   = i_countIsect;
        cap.countSymdiff = i_countSymdiff;
`ifdef CORR_WINDOW_SEQNUM_EN
        cap.seqNum       = seq_q;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            wc_q    <= '0;
            exp_q   <= '0;
            drop_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            exp_q   <= exp_d;
            drop_q  <= drop_d;
            seq_q   <= seq_d;
        end
    end

    corr_result_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (capture),
        .i_data  (cap),
        .i_ready (i_ready),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_data  (head)
    );

    assign o_windowLengthExp = exp_q;
    assign o_zeroCounts      = (state_q == IDLE) || (wc_q == '0);
    assign o_valid           = !fifo_empty;
    assign o_countX          = head.countX;
    assign o_countY          = head.countY;
    assign o_countIsect      = head.countIsect;
    assign o_countSymdiff    = head.countSymdiff;
    assign o_dropCount       = drop_q;
`ifdef CORR_WINDOW_SEQNUM_EN
    assign o_seqNum          = head.seqNum;
`endif

endmodule

// File: tb/tb_corr_window_seq.sv
// Directed self-checking bench for corr_window_seq.
module tb_corr_window_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cg;
    logic       en;
    logic [3:0] exp_i;
    logic [3:0] exp_o;
    logic       zc;
    logic [7:0] cx, cy, ci, cs;
    logic       vld;
    logic       rdy;
    logic [7:0] ox, oy, oi, os;
    logic [7:0] drop;
    logic [15:0] seq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       cg;
        logic       en;
        logic [3:0] exp;
        logic       rdy;
        logic       zc;
        logic       vld;
        logic [3:0] expo;
        logic [15:0] seq;
    } vec_t;

    vec_t tbl [26];

    always #5 clk = ~clk;

    corr_window_seq dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cg              (cg),
        .i_enable          (en),
        .i_windowLengthExp (exp_i),
        .o_windowLengthExp (exp_o),
        .o_zeroCounts      (zc),
        .i_countX          (cx),
        .i_countY          (cy),
        .i_countIsect      (ci),
        .i_countSymdiff    (cs),
        .o_valid           (vld),
        .i_ready           (rdy),
        .o_countX          (ox),
        .o_countY          (oy),
        .o_countIsect      (oi),
        .o_countSymdiff    (os),
        .o_dropCount       (drop)
`ifdef CORR_WINDOW_SEQNUM_EN
        ,
        .o_seqNum          (seq)
`endif
    );

`ifndef CORR_WINDOW_SEQNUM_EN
    assign seq = 16'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic chk_seq(input string nm, input logic [15:0] want);
`ifdef CORR_WINDOW_SEQNUM_EN
        chk(nm, 32'(seq), 32'(want));
`else
        if (want == 16'hffff) $display("note: %s", nm);
`endif
    endtask

    task automatic set_counts(input logic [7:0] b);
        cx = b;
        cy = b + 8'd1;
        ci = b + 8'd2;
        cs = b + 8'd3;
    endtask

    task automatic chk_head(input string nm, input logic [7:0] b);
        chk({nm, ".x"}, 32'(ox), 32'(b));
        chk({nm, ".y"}, 32'(oy), 32'(b + 8'd1));
        chk({nm, ".i"}, 32'(oi), 32'(b + 8'd2));
        chk({nm, ".s"}, 32'(os), 32'(b + 8'd3));
    endtask

    initial begin
        // Idle vector, then a run with exp=3 and a 3->2 change at edge 10.
        tbl[0] = '{cg: 1'b1, en: 1'b0, exp: 4'd3, rdy: 1'b1,
                   zc: 1'b1, vld: 1'b0, expo: 4'd3, seq: 16'd0};
        for (int e = 0; e < 25; e++) begin
            tbl[e+1].cg   = 1'b1;
            tbl[e+1].en   = 1'b1;
            tbl[e+1].exp  = (e < 10) ? 4'd3 : 4'd2;
            tbl[e+1].rdy  = 1'b1;
            tbl[e+1].zc   = (e == 7) || (e == 15) || (e == 19) || (e == 23);
            tbl[e+1].vld  = (e == 8) || (e == 16) || (e == 20) || (e == 24);
            tbl[e+1].expo = (e < 16) ? 4'd3 : 4'd2;
            tbl[e+1].seq  = (e == 8)  ? 16'd0 :
                            (e == 16) ? 16'd1 :
                            (e == 20) ? 16'd2 : 16'd3;
        end

        rst_n = 1'b0;
        cg    = 1'b1;
        en    = 1'b0;
        exp_i = 4'd0;
        rdy   = 1'b1;
        set_counts(8'h00);
        #2;
        chk("rst.zc",   32'(zc),    32'd1);
        chk("rst.vld",  32'(vld),   32'd0);
        chk("rst.drop", 32'(drop),  32'd0);
        chk("rst.exp",  32'(exp_o), 32'd0);
        chk("rst.cx",   32'(ox),    32'd0);
        #20;
        rst_n = 1'b1;

        cx = 8'h11; cy = 8'h22; ci = 8'h33; cs = 8'h44;
        for (int i = 0; i < 26; i++) begin
            cg    = tbl[i].cg;
            en    = tbl[i].en;
            exp_i = tbl[i].exp;
            rdy   = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d.zc", i),  32'(zc),    32'(tbl[i].zc));
            chk($sformatf("tbl%0d.vld", i), 32'(vld),   32'(tbl[i].vld));
            chk($sformatf("tbl%0d.exp", i), 32'(exp_o), 32'(tbl[i].expo));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d.x", i), 32'(ox), 32'h11);
                chk($sformatf("tbl%0d.y", i), 32'(oy), 32'h22);
                chk($sformatf("tbl%0d.i", i), 32'(oi), 32'h33);
                chk($sformatf("tbl%0d.s", i), 32'(os), 32'h44);
                chk_seq($sformatf("tbl%0d.seq", i), tbl[i].seq);
            end
        end

        // Back-pressure with exp=1: two buffered, three dropped.
        en = 1'b0; exp_i = 4'd1;
        step();
        chk("bp.idle.zc",  32'(zc),    32'd1);
        chk("bp.idle.vld", 32'(vld),   32'd0);
        chk("bp.idle.exp", 32'(exp_o), 32'd2);
        rdy = 1'b0;
        step();
        chk("bp.exp1", 32'(exp_o), 32'd1);
        en = 1'b1;
        for (int n = 0; n <= 10; n++) begin
            set_counts(8'(n));
            step();
            if (n == 2) begin
                chk("bp.first.vld", 32'(vld), 32'd1);
                chk_head("bp.first", 8'd2);
            end
            if (n == 6) chk("bp.drop1", 32'(drop), 32'd1);
        end
        chk("bp.drop3", 32'(drop), 32'd3);
        en = 1'b0;
        step();
        chk("bp.hold.vld", 32'(vld), 32'd1);
        chk_head("bp.hold0", 8'd2);
        chk_seq("bp.seq0", 16'd0);
        step();
        chk_head("bp.hold1", 8'd2);
        rdy = 1'b1;
        step();
        chk("bp.second.vld", 32'(vld), 32'd1);
        chk_head("bp.second", 8'd4);
        chk_seq("bp.seq1", 16'd1);
        step();
        chk("bp.drained", 32'(vld), 32'd0);
        chk("bp.drop.kept", 32'(drop), 32'd3);

        // Clock-gate freeze mid-window.
        cx = 8'h11; cy = 8'h22; ci = 8'h33; cs = 8'h44;
        exp_i = 4'd3;
        step();
        chk("cg.exp3", 32'(exp_o), 32'd3);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("cg.pre%0d.zc", k), 32'(zc), 32'd0);
        end
        cg = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("cg.frz%0d.zc", k), 32'(zc), 32'd0);
        end
        cg = 1'b1;
        step();
        chk("cg.post0.zc", 32'(zc), 32'd0);
        step();
        chk("cg.post1.zc", 32'(zc), 32'd0);
        step();
        chk("cg.bound.zc", 32'(zc), 32'd1);
        chk("cg.bound.vld", 32'(vld), 32'd0);
        rdy = 1'b0;
        step();
        chk("cg.cap.vld", 32'(vld), 32'd1);
        chk("cg.cap.zc",  32'(zc),  32'd0);
        chk("cg.cap.x",   32'(ox),  32'h11);
        chk_seq("cg.cap.seq", 16'd0);
        cg = 1'b0;
        step();
        chk("cg.hs.hold", 32'(vld), 32'd1);
        rdy = 1'b1;
        step();
        chk("cg.hs.pop", 32'(vld), 32'd0);

        // Disable after five cycles of a window: no capture.
        cg = 1'b1; en = 1'b0;
        step();
        chk("dis.idle.zc", 32'(zc), 32'd1);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("dis.run%0d.zc", k), 32'(zc), 32'd0);
        end
        en = 1'b0;
        step();
        chk("dis.stop.zc",  32'(zc),  32'd1);
        chk("dis.stop.vld", 32'(vld), 32'd0);
        step();
        chk("dis.idle2.vld", 32'(vld), 32'd0);
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 7) chk("re.bound.zc", 32'(zc), 32'd1);
        end
        chk("re.cap.vld", 32'(vld), 32'd1);
        chk("re.cap.x",   32'(ox),  32'h11);
        chk_seq("re.cap.seq", 16'd0);

        // exp=0: every run cycle is a boundary; then saturate drops.
        en = 1'b0; exp_i = 4'd0;
        step();
        rdy = 1'b0;
        set_counts(8'h00);
        step();
        chk("e0.exp", 32'(exp_o), 32'd0);
        en = 1'b1;
        step();
        chk("e0.start.zc",  32'(zc),  32'd1);
        chk("e0.start.vld", 32'(vld), 32'd0);
        step();
        chk("e0.c1.zc",  32'(zc),  32'd1);
        chk("e0.c1.vld", 32'(vld), 32'd1);
        chk_head("e0.c1", 8'h00);
        step();
        step();
        chk("e0.drop4", 32'(drop), 32'd4);
        for (int k = 0; k < 260; k++) step();
        chk("e0.sat", 32'(drop), 32'd255);
        chk("e0.sat.zc", 32'(zc), 32'd1);

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld",  32'(vld),   32'd0);
        chk("arst.drop", 32'(drop),  32'd0);
        chk("arst.zc",   32'(zc),    32'd1);
        chk("arst.exp",  32'(exp_o), 32'd0);
        chk("arst.x",    32'(ox),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
